tile_scheduler: RTL and testbench

//  Outer-loop sequencer above the per-tile systolic controller. Walks a GEMM layer as N output tiles x K

---
 rtl/tile_scheduler.sv | 164 ++++++++++++++++
 tb/tb_tile_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_scheduler.sv
// Outer-loop GEMM sequencer: walks N output tiles x K reduction tiles, launching the
// per-tile core once per (n,k) and requesting one write-back after each N tile's last K tile.
module tile_scheduler #(
  parameter int IDX_W           = 8,
  parameter int WATCHDOG_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ap_start,
  input  logic [IDX_W-1:0] cfg_n_tiles,
  input  logic [IDX_W-1:0] cfg_k_tiles,
  input  logic [31:0]      cfg_seq_len,
  output logic             ap_done,
  output logic             ap_idle,
  output logic             err_cfg,
  output logic             err_timeout,
  output logic [2:0]       state_dbg,
  output logic             core_start,
  output logic [31:0]      core_seq_len,
  input  logic             core_done,
  input  logic             core_idle,
  output logic [IDX_W-1:0] tile_n_idx,
  output logic [IDX_W-1:0] tile_k_idx,
  output logic             acc_clear,
  output logic             wb_req,
  input  logic             wb_ack
);

  localparam int              WD_W    = $clog2(WATCHDOG_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_WB     = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state, state_d;
  logic [IDX_W-1:0] n_tiles, n_tiles_d, k_tiles, k_tiles_d;
  logic [IDX_W-1:0] n_idx_d, k_idx_d;
  logic [31:0]      seq_len_d;
  logic [WD_W-1:0]  wd, wd_d, wd_inc;
  logic             core_start_d, acc_clear_d, wb_req_d, ap_done_d;
  logic             err_cfg_d, err_timeout_d;
  logic             k_last, n_last;

  assign state_dbg = state;
  assign wd_inc    = wd + WD_W'(1);
  assign k_last    = (tile_k_idx == k_tiles - IDX_W'(1));
  assign n_last    = (tile_n_idx == n_tiles - IDX_W'(1));

  always_comb begin
    state_d       = state;
    n_tiles_d     = n_tiles;
    k_tiles_d     = k_tiles;
    n_idx_d       = tile_n_idx;
    k_idx_d       = tile_k_idx;
    seq_len_d     = core_seq_len;
    wd_d          = wd;
    core_start_d  = 1'b0;
    acc_clear_d   = acc_clear;
    wb_req_d      = wb_req;
    ap_done_d     = 1'b0;
    err_cfg_d     = err_cfg;
    err_timeout_d = err_timeout;
    case (state)
      S_IDLE: begin
        if (ap_start) begin
          n_tiles_d     = cfg_n_tiles;
          k_tiles_d     = cfg_k_tiles;
          seq_len_d     = cfg_seq_len;
          n_idx_d       = '0;
          k_idx_d       = '0;
          err_cfg_d     = 1'b0;
          err_timeout_d = 1'b0;
          if (cfg_n_tiles == '0 || cfg_k_tiles == '0) begin
            err_cfg_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        if (core_idle) begin
          core_start_d = 1'b1;
          acc_clear_d  = (tile_k_idx == '0);
          wd_d         = '0;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        wd_d = wd_inc;
        // A done seen while our own start pulse is still high belongs to the previous tile.
        if (core_done && !core_start) begin
          if (k_last) begin
            wb_req_d = 1'b1;
            state_d  = S_WB;
          end else begin
            k_idx_d = tile_k_idx + IDX_W'(1);
            state_d = S_LAUNCH;
          end
        end else if (wd_inc == WD_LAST) begin
          err_timeout_d = 1'b1;
          state_d       = S_DONE;
        end
      end
      S_WB: begin
        if (wb_ack) begin
          wb_req_d = 1'b0;
          if (n_last) begin
            state_d = S_DONE;
          end else begin
            n_idx_d = tile_n_idx + IDX_W'(1);
            k_idx_d = '0;
            state_d = S_LAUNCH;
          end
        end
      end
      S_DONE: begin
        ap_done_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      n_tiles      <= '0;
      k_tiles      <= '0;
      tile_n_idx   <= '0;
      tile_k_idx   <= '0;
      core_seq_len <= '0;
      wd           <= '0;
      core_start   <= 1'b0;
      acc_clear    <= 1'b0;
      wb_req       <= 1'b0;
      ap_done      <= 1'b0;
      ap_idle      <= 1'b1;
      err_cfg      <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state        <= state_d;
      n_tiles      <= n_tiles_d;
      k_tiles      <= k_tiles_d;
      tile_n_idx   <= n_idx_d;
      tile_k_idx   <= k_idx_d;
      core_seq_len <= seq_len_d;
      wd           <= wd_d;
      core_start   <= core_start_d;
      acc_clear    <= acc_clear_d;
      wb_req       <= wb_req_d;
      ap_done      <= ap_done_d;
      ap_idle      <= (state_d == S_IDLE);
      err_cfg      <= err_cfg_d;
      err_timeout  <= err_timeout_d;
    end
  end

endmodule

// File: tb/tb_tile_scheduler.sv
// Bench for tile_scheduler: directed layer runs with expected launches, write-backs and
// completions queued up front and checked by an independent output monitor.
module tb_tile_scheduler;
  localparam int IDX_W = 8;
  localparam int W     = 2 * IDX_W + 1 + 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ap_start;
  logic [IDX_W-1:0] cfg_n_tiles, cfg_k_tiles;
  logic [31:0]      cfg_seq_len;
  logic             ap_done, ap_idle, err_cfg, err_timeout;
  logic [2:0]       state_dbg;
  logic             core_start;
  logic [31:0]      core_seq_len;
  logic             core_done, core_idle;
  logic [IDX_W-1:0] tile_n_idx, tile_k_idx;
  logic             acc_clear, wb_req, wb_ack;
  logic             wb_ack_model, wb_ack_stray;

  int core_lat, wb_delay, exp_wb_len;
  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0]       exp_start_q[$];
  logic [IDX_W-1:0]   exp_wb_q[$];
  logic [1:0]         exp_done_q[$];

  assign wb_ack = wb_ack_model | wb_ack_stray;

  always #5 clk = ~clk;

  tile_scheduler #(.IDX_W(IDX_W), .WATCHDOG_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n), .ap_start(ap_start),
    .cfg_n_tiles(cfg_n_tiles), .cfg_k_tiles(cfg_k_tiles), .cfg_seq_len(cfg_seq_len),
    .ap_done(ap_done), .ap_idle(ap_idle), .err_cfg(err_cfg), .err_timeout(err_timeout),
    .state_dbg(state_dbg), .core_start(core_start), .core_seq_len(core_seq_len),
    .core_done(core_done), .core_idle(core_idle),
    .tile_n_idx(tile_n_idx), .tile_k_idx(tile_k_idx), .acc_clear(acc_clear),
    .wb_req(wb_req), .wb_ack(wb_ack)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_start(input int n, input int k, input bit acc,
                                             input logic [31:0] seq);
    return {IDX_W'(n), IDX_W'(k), acc, seq};
  endfunction

  // Core model: done pulse core_lat cycles after each start (0 = never answers).
  initial begin : core_model
    int cnt;
    cnt = 0;
    core_done = 1'b0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (!rst_n) cnt = 0;
      else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) core_done = 1'b1;
        end
        if (core_start && core_lat > 0) cnt = core_lat;
      end
    end
  end

  // Write-back model: ack pulse wb_delay cycles after wb_req rises.
  initial begin : wb_model
    int cnt;
    bit seen;
    cnt = 0;
    seen = 0;
    wb_ack_model = 1'b0;
    forever begin
      @(negedge clk);
      wb_ack_model = 1'b0;
      if (!wb_req || !rst_n) seen = 0;
      else if (!seen) begin
        seen = 1;
        cnt = wb_delay;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) wb_ack_model = 1'b1;
      end
    end
  end

  initial begin : monitor
    logic [W-1:0] got;
    logic         cs_prev, wb_prev;
    int           wb_len;
    cs_prev = 0;
    wb_prev = 0;
    wb_len  = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cs_prev = 0;
        wb_prev = 0;
        wb_len  = 0;
      end else begin
        if (core_start) begin
          check("core_start_single_pulse", cs_prev, 0);
          got = {tile_n_idx, tile_k_idx, acc_clear, core_seq_len};
          if (exp_start_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL core_start_unexpected: got n=%0d k=%0d expected none", tile_n_idx, tile_k_idx);
          end else check("core_start_fields", got, exp_start_q.pop_front());
        end
        if (wb_req && !wb_prev) begin
          if (exp_wb_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL wb_req_unexpected: got n=%0d expected none", tile_n_idx);
          end else check("wb_req_n_idx", tile_n_idx, exp_wb_q.pop_front());
        end
        if (wb_req) wb_len++;
        if (!wb_req && wb_prev) begin
          check("wb_req_len", wb_len, exp_wb_len);
          wb_len = 0;
        end
        if (ap_done) begin
          if (exp_done_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL ap_done_unexpected: got 1 expected 0");
          end else check("ap_done_errs", {err_cfg, err_timeout}, exp_done_q.pop_front());
        end
        cs_prev = core_start;
        wb_prev = wb_req;
      end
    end
  end

  task automatic pulse_start();
    ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (!ap_done && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("ap_done_seen", ap_done, 1);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic check_queues_empty(input string tag);
    check({tag, "_start_q_empty"}, exp_start_q.size(), 0);
    check({tag, "_wb_q_empty"}, exp_wb_q.size(), 0);
    check({tag, "_done_q_empty"}, exp_done_q.size(), 0);
  endtask

  initial begin : stimulus
    int j, bad;
    rst_n = 1'b0; ap_start = 1'b0; cfg_n_tiles = '0; cfg_k_tiles = '0; cfg_seq_len = '0;
    core_idle = 1'b1; wb_ack_stray = 1'b0;
    core_lat = 40; wb_delay = 1; exp_wb_len = 2;
    repeat (3) @(negedge clk);
    check("rst_ap_idle", ap_idle, 1);
    check("rst_outputs", {ap_done, err_cfg, err_timeout, core_start, acc_clear, wb_req}, 0);
    check("rst_state_idx", {state_dbg, tile_n_idx, tile_k_idx, core_seq_len}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full 2x3 layer
    cfg_n_tiles = 2; cfg_k_tiles = 3; cfg_seq_len = 32'h100;
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 3; k++) exp_start_q.push_back(mk_start(n, k, k == 0, 32'h100));
      exp_wb_q.push_back(IDX_W'(n));
    end
    exp_done_q.push_back(2'b00);
    pulse_start();
    check("latency_cs_early", core_start, 0);
    @(negedge clk);
    check("latency_cs_2cyc", core_start, 1);
    wait_done(1000);
    check_queues_empty("layer");
    check("layer_idle_after", ap_idle, 1);

    // Zero tile count
    cfg_n_tiles = 0; cfg_k_tiles = 4;
    exp_done_q.push_back(2'b10);
    pulse_start();
    check("cfg_err_done_early", ap_done, 0);
    @(negedge clk);
    check("cfg_err_done_2cyc", ap_done, 1);
    check("cfg_err_flag", err_cfg, 1);
    repeat (2) @(negedge clk);
    check("cfg_err_sticky", err_cfg, 1);
    check_queues_empty("cfgerr");

    // core_idle held low in S_LAUNCH
    cfg_n_tiles = 1; cfg_k_tiles = 1; cfg_seq_len = 32'hABCD; core_lat = 5;
    core_idle = 1'b0;
    exp_start_q.push_back(mk_start(0, 0, 1, 32'hABCD));
    exp_wb_q.push_back(0);
    exp_done_q.push_back(2'b00);
    pulse_start();
    check("cfg_err_cleared", err_cfg, 0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (core_start) bad++;
      @(negedge clk);
    end
    check("launch_blocked", bad, 0);
    check("launch_state", state_dbg, 1);
    core_idle = 1'b1;
    @(negedge clk);
    check("launch_after_idle", core_start, 1);
    wait_done(200);
    check_queues_empty("idlehold");

    // Watchdog
    core_lat = 0; cfg_seq_len = 32'h7;
    exp_start_q.push_back(mk_start(0, 0, 1, 32'h7));
    exp_done_q.push_back(2'b01);
    pulse_start();
    @(negedge clk);
    check("wd_core_start", core_start, 1);
    j = 0;
    while (!err_timeout && j < 200) begin
      @(negedge clk);
      j++;
    end
    check("wd_fire_offset", j, 63);
    @(negedge clk);
    check("wd_then_done", ap_done, 1);
    wait_done(10);
    check("wd_sticky", err_timeout, 1);
    check_queues_empty("wd");

    // Delayed wb_ack plus stray pulses in S_WAIT
    core_lat = 20; wb_delay = 5; exp_wb_len = 6;
    cfg_n_tiles = 1; cfg_k_tiles = 1; cfg_seq_len = 32'h55;
    exp_start_q.push_back(mk_start(0, 0, 1, 32'h55));
    exp_wb_q.push_back(0);
    exp_done_q.push_back(2'b00);
    pulse_start();
    check("wd_err_cleared", err_timeout, 0);
    repeat (6) @(negedge clk);
    check("stray_in_wait", state_dbg, 2);
    wb_ack_stray = 1'b1;
    @(negedge clk);
    wb_ack_stray = 1'b0;
    cfg_n_tiles = 5;
    ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
    check("stray_still_wait", state_dbg, 2);
    wait_done(200);
    check_queues_empty("stray");

    // Reset during S_WAIT at n=1,k=1
    core_lat = 30; wb_delay = 1; exp_wb_len = 2;
    cfg_n_tiles = 2; cfg_k_tiles = 2; cfg_seq_len = 32'h99;
    exp_start_q.push_back(mk_start(0, 0, 1, 32'h99));
    exp_start_q.push_back(mk_start(0, 1, 0, 32'h99));
    exp_start_q.push_back(mk_start(1, 0, 1, 32'h99));
    exp_start_q.push_back(mk_start(1, 1, 0, 32'h99));
    exp_wb_q.push_back(0);
    pulse_start();
    j = 0;
    while (!(state_dbg == 3'd2 && tile_n_idx == 1 && tile_k_idx == 1) && j < 500) begin
      @(negedge clk);
      j++;
    end
    check("rst_reach_n1k1", j < 500, 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ap_idle", ap_idle, 1);
    check("midrst_idx", {state_dbg, tile_n_idx, tile_k_idx, core_seq_len}, 0);
    check("midrst_outputs", {ap_done, core_start, wb_req, err_cfg, err_timeout}, 0);
    check_queues_empty("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (core_start || wb_req || ap_done) bad++;
    end
    check("midrst_quiet", bad, 0);
    core_lat = 5;
    cfg_n_tiles = 1; cfg_k_tiles = 1; cfg_seq_len = 32'h11;
    exp_start_q.push_back(mk_start(0, 0, 1, 32'h11));
    exp_wb_q.push_back(0);
    exp_done_q.push_back(2'b00);
    pulse_start();
    wait_done(200);
    check_queues_empty("fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
